// File: rtl/kb_serial_pkg.sv
`default_nettype none
// ============================================================================
// kb_serial_pkg : constants and FSM state type shared by keypad serial TX/RX
// Revision      : 1.0 - initial release
// ============================================================================
package kb_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

  localparam int KEY_W     = 4;
  localparam int FRAME_LEN = 1 + KEY_W;

endpackage : kb_serial_pkg
`default_nettype wire

// File: rtl/kb_sync_fifo.sv
`default_nettype none
// ============================================================================
// kb_sync_fifo : small synchronous FIFO, head word decoded from stored state
// Revision     : 1.0 - initial release
// ============================================================================
module kb_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    // A push while full is refused even if a pop frees a slot on this edge.
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : kb_sync_fifo
`default_nettype wire

// File: rtl/keypad_serial_tx.sv
`default_nettype none
// ============================================================================
// keypad_serial_tx : buffers scanner key codes and sends them as a KBinit
//                    start pulse followed by MSB-first data bits
// Revision         : 1.0 - initial release
// ============================================================================
module keypad_serial_tx
  import kb_serial_pkg::*;
#(
  parameter int DATA_W     = KEY_W,
  parameter int FIFO_DEPTH = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] key_code,
  input  logic              key_valid,
  output logic              key_ready,
  output logic              KBinit,
  output logic              serialO,
  output logic              tx_busy,
  output logic              drop_pulse
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              kbinit_q, kbinit_d;
  logic              serial_q, serial_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign key_ready = !fifo_full;
  assign fifo_push = key_valid && key_ready;

  kb_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (key_code),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = START;
        end
      end
      START: begin
        bit_cnt_d = BIT_W'(DATA_W - 1);
        state_d   = DATA;
      end
      DATA: begin
        if (bit_cnt_q == '0) begin
          gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
          state_d   = GAP;
        end else begin
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    kbinit_d = (state_d == START);
    serial_d = (state_d == DATA) ? shift_d[bit_cnt_d] : 1'b0;
    busy_d   = (state_d != IDLE);
    drop_d   = key_valid && !key_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      kbinit_q  <= 1'b0;
      serial_q  <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      kbinit_q  <= kbinit_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  assign KBinit     = kbinit_q;
  assign serialO    = serial_q;
  assign tx_busy    = busy_q;
  assign drop_pulse = drop_q;

endmodule : keypad_serial_tx
`default_nettype wire

// File: tb/tb_keypad_serial_tx.sv
`default_nettype none
// ============================================================================
// tb_keypad_serial_tx : directed self-checking bench for keypad_serial_tx
// Revision            : 1.0 - initial release
// ============================================================================
module tb_keypad_serial_tx;
  import kb_serial_pkg::*;

  localparam int DW  = FRAME_LEN - 1;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] key_code;
  logic          key_valid;
  logic          key_ready, KBinit, serialO, tx_busy, drop_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_serial_tx #(
    .DATA_W     (DW),
    .FIFO_DEPTH (2),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .KBinit     (KBinit),
    .serialO    (serialO),
    .tx_busy    (tx_busy),
    .drop_pulse (drop_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in the KBinit cycle; leaves in the last gap cycle.
  task automatic frame(input string tag, input logic [DW-1:0] code);
    chk({tag, " start"}, {29'd0, KBinit, serialO, tx_busy}, 32'b101);
    for (int i = DW - 1; i >= 0; i--) begin
      tick();
      chk({tag, " data"}, {29'd0, KBinit, serialO, tx_busy}, {29'd0, 1'b0, code[i], 1'b1});
    end
    for (int g = 0; g < GAP; g++) begin
      tick();
      chk({tag, " gap"}, {29'd0, KBinit, serialO, tx_busy}, 32'b001);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    key_code  = '0;
    key_valid = 1'b0;
    tick(); tick();
    chk("reset", {27'd0, KBinit, serialO, tx_busy, drop_pulse, key_ready}, 32'b00001);
    rst_n = 1'b1;

    // Single key 0xA
    key_code = 4'hA; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("single idle1", {30'd0, KBinit, tx_busy}, 32'b00);
    tick();
    frame("single", 4'hA);
    tick();
    chk("single done", {30'd0, tx_busy, key_ready}, 32'b01);

    // Back-to-back 0x3 then 0xC
    key_code = 4'h3; key_valid = 1'b1;
    tick();
    chk("b2b ready", {31'd0, key_ready}, 32'd1);
    key_code = 4'hC;
    tick();
    key_valid = 1'b0;
    frame("b2b first", 4'h3);
    tick();
    frame("b2b second", 4'hC);
    tick();
    chk("b2b done", {31'd0, tx_busy}, 32'd0);

    // Overflow: codes 1..4 on consecutive cycles, depth-2 FIFO
    key_code = 4'h1; key_valid = 1'b1;
    tick();
    chk("ovf a0", {30'd0, key_ready, drop_pulse}, 32'b10);
    key_code = 4'h2;
    tick();
    chk("ovf a1", {29'd0, key_ready, drop_pulse, KBinit}, 32'b101);
    key_code = 4'h3;
    tick();
    chk("ovf a2", {29'd0, key_ready, drop_pulse, serialO}, 32'b000);
    key_code = 4'h4;
    tick();
    key_valid = 1'b0;
    chk("ovf drop", {29'd0, key_ready, drop_pulse, serialO}, 32'b010);
    tick();
    chk("ovf a4", {30'd0, drop_pulse, serialO}, 32'b00);
    tick();
    chk("ovf lsb", {30'd0, KBinit, serialO}, 32'b01);
    tick(); tick();
    tick();
    frame("ovf code2", 4'h2);
    tick();
    frame("ovf code3", 4'h3);
    tick();
    chk("ovf done", {30'd0, tx_busy, key_ready}, 32'b01);

    // Reset during the second data bit of 0xF
    key_code = 4'hF; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    chk("rst kbinit", {31'd0, KBinit}, 32'd1);
    tick(); tick();
    chk("rst bit2", {30'd0, serialO, tx_busy}, 32'b11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst abort", {28'd0, KBinit, serialO, tx_busy, key_ready}, 32'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst quiet", {29'd0, KBinit, serialO, tx_busy}, 32'b000);
    end

    // Idle
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle", {27'd0, KBinit, serialO, tx_busy, drop_pulse, key_ready}, 32'b00001);
    end

    // Pointer wrap: codes 0..9, one every 8 cycles
    for (int c = 0; c < 10; c++) begin
      key_code = DW'(c); key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      tick();
      frame("wrap", DW'(c));
      chk("wrap ready", {31'd0, key_ready}, 32'd1);
    end
    tick();
    chk("wrap done", {31'd0, tx_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_keypad_serial_tx
`default_nettype wire

// File: doc/keypad_serial_tx.md
Name: keypad_serial_tx

Overview:
- Upstream neighbour of the keypad serial receiver in the alarm panel.
- Accepts 4-bit key codes from the keypad scanner over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each code as a one-cycle KBinit start pulse followed by the data bits, MSB first, on a single line.
- Enforces a configurable idle gap between frames so the receiver always re-arms.

Parameters:
- DATA_W, 4, key code width / number of serial data bits per frame.
- FIFO_DEPTH, 2, key code buffer entries (power of two, >=2).
- GAP_CYCLES, 2, idle cycles after the last data bit before the next frame's start pulse (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- key_code  in  DATA_W  key code from the scanner.
- key_valid  in  1  key_code is valid this cycle.
- key_ready  out  1  block can accept a code this cycle.
- KBinit  out  1  frame start pulse to the receiver.
- serialO  out  1  serial data line.
- tx_busy  out  1  a frame is in progress (START, DATA or GAP).
- drop_pulse  out  1  one-cycle pulse when key_valid=1 while key_ready=0.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO is emptied; FSM goes to IDLE.
  - KBinit=0, serialO=0, tx_busy=0, drop_pulse=0, key_ready=1 from the first cycle after reset.
  - Reset mid-frame aborts the frame immediately; the partial frame is not resent.
- Handshake:
  - key_ready = !fifo_full, from registered state only; there is no combinational path from key_valid.
  - A code is accepted on an edge where key_valid && key_ready, and is written to the FIFO.
  - A push while full is rejected even if a pop happens on the same edge; drop_pulse is asserted in the following cycle.
  - Push and pop on the same edge when the FIFO is not full: both take effect and the count is unchanged.
- FSM states: IDLE, START, DATA, GAP. All outputs are registered.
  - IDLE: if the FIFO is non-empty, pop the head into shift_reg and go to START.
  - START: lasts 1 cycle; KBinit=1, serialO=0; load bit_cnt=DATA_W-1; go to DATA.
  - DATA: lasts DATA_W cycles; serialO=shift_reg[bit_cnt], i.e. MSB first; KBinit=0; at bit_cnt==0 go to GAP with gap_cnt=GAP_CYCLES-1.
  - GAP: serialO=0, KBinit=0. At gap_cnt==0, pop and go straight to START if the FIFO is non-empty, else go to IDLE.
- Latency:
  - A code accepted at edge E into an idle, empty block is popped at E+1.
  - KBinit is high in the cycle after E+1.
  - The data bits are on serialO in the 4 cycles after that.
  - First bit to last bit spans DATA_W cycles.
- Throughput: back-to-back frame period = 1 + DATA_W + GAP_CYCLES cycles (7 with defaults).
- tx_busy is 1 in START, DATA and GAP, and 0 only in IDLE.
- Counters:
  - bit_cnt is $clog2(DATA_W) bits; gap_cnt is $clog2(GAP_CYCLES+1) bits.
  - FIFO pointers wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits.
- KBinit never asserts in two consecutive cycles; serialO is 0 whenever the FSM is outside DATA.

Decomposition:
- Shared package kb_serial_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, GAP};
  - localparam KEY_W=4;
  - localparam FRAME_LEN=1+KEY_W. The receiver uses the same constants.
- One sub-module, kb_sync_fifo:
  - parameterised WIDTH and DEPTH; synchronous active-low reset;
  - push/pop/full/empty; registered head output.
- The top level holds the FSM, shift register and counters.

Test Plan:
- Single key: after reset, key_code=4'hA with key_valid for 1 cycle -> KBinit=1 exactly 2 cycles after acceptance, then serialO=1,0,1,0 on the next 4 cycles, then tx_busy=0 after 2 gap cycles.
- Back-to-back: push 4'h3 then 4'hC on consecutive cycles -> two frames, with KBinit pulses 7 cycles apart and serialO bits 0011 then 1100.
- Overflow: hold key_valid=1 with codes 1,2,3,4 on 4 consecutive cycles from idle -> key_ready drops after the FIFO fills; drop_pulse fires for each rejected code; only the accepted codes are transmitted, in order, with no corruption.
- Reset mid-frame: assert rst_n=0 during the second data bit of 4'hF -> next cycle KBinit=0, serialO=0, tx_busy=0, key_ready=1; no further bits of that frame are sent.
- Idle behaviour: key_valid=0 for 50 cycles -> KBinit, serialO and tx_busy stay 0; key_ready stays 1.
- Pointer wrap: send 10 sequential codes 0..9, spaced 8 cycles apart -> every frame is correct and the FIFO pointers wrap cleanly.
